// File: rtl/midi_tx_arbiter.sv
// midi_tx_arbiter: message-aware round-robin merge of four MIDI source FIFOs
// into one transmit byte stream. A grant is held until a complete MIDI message
// (including running status and SysEx) has been forwarded.
// Optional feature macro: MIDI_ARB_RT_BYPASS_EN lets single-byte real-time
// messages (F8-FF) from non-granted sources cut in between granted bytes.
//
// state | meaning
// IDLE  | no grant; scan sources round-robin from the pointer
// SEND  | forward (or drop) one byte of the granted source, or wait for it
// GAP   | one settle cycle after a pop; release the grant if message complete
module midi_tx_arbiter #(
   parameter logic [15:0] TIMEOUT_CYCLES = 16'd1000
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [31:0] src_data_i,
   input  logic [3:0]  src_rdy_i,
   output logic [3:0]  src_rd_o,
   output logic [7:0]  out_data_o,
   output logic        out_wr_o,
   input  logic        out_full_n_i,
   output logic [3:0]  grant_o,
   output logic        err_drop_o,
   output logic        err_timeout_o
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_SEND = 2'd1;
   localparam logic [1:0] ST_GAP  = 2'd2;

   logic [1:0]  state_q, state_d;
   logic [1:0]  ptr_q, ptr_d;
   logic [1:0]  gidx_q, gidx_d;
   logic [3:0]  grant_q, grant_d;
   logic [1:0]  rem_q, rem_d;
   logic        sysex_q, sysex_d;
   logic        done_q, done_d;
   logic [15:0] tmo_q, tmo_d;
   // Running status is kept only as "valid" plus "3-byte message class";
   // that is all the data-byte-at-start rule ever needs from it.
   logic [3:0]  rs_vld_q, rs_vld_d;
   logic [3:0]  rs_len3_q, rs_len3_d;
   logic [3:0]  src_rd_q, src_rd_d;
   logic [7:0]  out_data_q, out_data_d;
   logic        out_wr_q, out_wr_d;
   logic        err_drop_q, err_drop_d;
   logic        err_tmo_q, err_tmo_d;

   logic        sel_hit;
   logic [1:0]  sel_idx;
   logic [1:0]  scan_idx;
   logic [7:0]  g_byte;
   logic        g_rdy;
   logic        at_start;

   assign g_byte   = src_data_i[{gidx_q, 3'b000} +: 8];
   assign g_rdy    = src_rdy_i[gidx_q];
   assign at_start = (rem_q == 2'd0) && !sysex_q;

   // Round-robin pick: first ready source at or after the pointer.
   always_comb begin
      sel_hit  = 1'b0;
      sel_idx  = ptr_q;
      scan_idx = ptr_q;
      for (int k = 3; k >= 0; k--) begin
         scan_idx = ptr_q + 2'(k);
         if (src_rdy_i[scan_idx]) begin
            sel_hit = 1'b1;
            sel_idx = scan_idx;
         end
      end
   end

`ifdef MIDI_ARB_RT_BYPASS_EN
   logic       rt_hit;
   logic [1:0] rt_idx;

   // Lowest-index non-granted source showing a real-time byte at its head.
   always_comb begin
      rt_hit = 1'b0;
      rt_idx = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (2'(i) != gidx_q && src_rdy_i[i] && src_data_i[8*i+3 +: 5] == 5'h1F) begin
            rt_hit = 1'b1;
            rt_idx = 2'(i);
         end
      end
   end
`endif

   // Next-state, message-length decode and strobe generation.
   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      gidx_d     = gidx_q;
      grant_d    = grant_q;
      rem_d      = rem_q;
      sysex_d    = sysex_q;
      done_d     = done_q;
      tmo_d      = tmo_q;
      rs_vld_d   = rs_vld_q;
      rs_len3_d  = rs_len3_q;
      src_rd_d   = 4'd0;
      out_data_d = out_data_q;
      out_wr_d   = 1'b0;
      err_drop_d = 1'b0;
      err_tmo_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (sel_hit) begin
               gidx_d  = sel_idx;
               grant_d = 4'b0001 << sel_idx;
               tmo_d   = 16'd0;
               done_d  = 1'b0;
               state_d = ST_SEND;
            end
         end
         ST_SEND: begin
`ifdef MIDI_ARB_RT_BYPASS_EN
            // A bypassed byte leaves the granted message's bookkeeping alone.
            if (rt_hit && out_full_n_i) begin
               src_rd_d[rt_idx] = 1'b1;
               out_wr_d         = 1'b1;
               out_data_d       = src_data_i[{rt_idx, 3'b000} +: 8];
               state_d          = ST_GAP;
            end else
`endif
            if (g_rdy && out_full_n_i) begin
               src_rd_d = grant_q;
               state_d  = ST_GAP;
               if (g_byte[7]) begin
                  out_wr_d   = 1'b1;
                  out_data_d = g_byte;
                  if (g_byte[7:3] != 5'h1F) begin
                     // Any non-real-time status restarts the message count.
                     rs_vld_d[gidx_q]  = 1'b0;
                     rs_len3_d[gidx_q] = 1'b0;
                     rem_d             = 2'd0;
                     sysex_d           = 1'b0;
                     if (g_byte[7:4] != 4'hF) begin
                        rs_vld_d[gidx_q]  = 1'b1;
                        rs_len3_d[gidx_q] = (g_byte[7:5] != 3'b110);
                        rem_d             = (g_byte[7:5] != 3'b110) ? 2'd2 : 2'd1;
                     end else begin
                        case (g_byte[3:0])
                           4'h0:       sysex_d = 1'b1;
                           4'h1, 4'h3: rem_d   = 2'd1;
                           4'h2:       rem_d   = 2'd2;
                           default:    ;
                        endcase
                     end
                  end
               end else if (at_start) begin
                  if (rs_vld_q[gidx_q]) begin
                     out_wr_d   = 1'b1;
                     out_data_d = g_byte;
                     rem_d      = rs_len3_q[gidx_q] ? 2'd1 : 2'd0;
                  end else begin
                     err_drop_d = 1'b1;
                  end
               end else begin
                  out_wr_d   = 1'b1;
                  out_data_d = g_byte;
                  if (rem_q != 2'd0) rem_d = rem_q - 2'd1;
               end
               done_d = (rem_d == 2'd0) && !sysex_d;
            end else if (!g_rdy) begin
               tmo_d = tmo_q + 16'd1;
               if (tmo_d == TIMEOUT_CYCLES) begin
                  err_tmo_d         = 1'b1;
                  rs_vld_d[gidx_q]  = 1'b0;
                  rs_len3_d[gidx_q] = 1'b0;
                  rem_d             = 2'd0;
                  sysex_d           = 1'b0;
                  grant_d           = 4'd0;
                  ptr_d             = gidx_q + 2'd1;
                  state_d           = ST_IDLE;
               end
            end
         end
         ST_GAP: begin
            if (done_q) begin
               grant_d = 4'd0;
               ptr_d   = gidx_q + 2'd1;
               state_d = ST_IDLE;
            end else begin
               state_d = ST_SEND;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and registered outputs, synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= ST_IDLE;
         ptr_q      <= 2'd0;
         gidx_q     <= 2'd0;
         grant_q    <= 4'd0;
         rem_q      <= 2'd0;
         sysex_q    <= 1'b0;
         done_q     <= 1'b0;
         tmo_q      <= 16'd0;
         rs_vld_q   <= 4'd0;
         rs_len3_q  <= 4'd0;
         src_rd_q   <= 4'd0;
         out_data_q <= 8'd0;
         out_wr_q   <= 1'b0;
         err_drop_q <= 1'b0;
         err_tmo_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         gidx_q     <= gidx_d;
         grant_q    <= grant_d;
         rem_q      <= rem_d;
         sysex_q    <= sysex_d;
         done_q     <= done_d;
         tmo_q      <= tmo_d;
         rs_vld_q   <= rs_vld_d;
         rs_len3_q  <= rs_len3_d;
         src_rd_q   <= src_rd_d;
         out_data_q <= out_data_d;
         out_wr_q   <= out_wr_d;
         err_drop_q <= err_drop_d;
         err_tmo_q  <= err_tmo_d;
      end
   end

   assign src_rd_o      = src_rd_q;
   assign out_data_o    = out_data_q;
   assign out_wr_o      = out_wr_q;
   assign grant_o       = grant_q;
   assign err_drop_o    = err_drop_q;
   assign err_timeout_o = err_tmo_q;

endmodule

// File: tb/tb_midi_tx_arbiter.sv
// Testbench for midi_tx_arbiter: directed message scenarios plus randomized
// preloaded traffic checked against a message-level round-robin model.
module tb_midi_tx_arbiter;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic [31:0] src_data_i = 32'd0;
   logic [3:0]  src_rdy_i = 4'd0;
   logic [3:0]  src_rd_o;
   logic [7:0]  out_data_o;
   logic        out_wr_o;
   logic        out_full_n_i = 1'b1;
   logic [3:0]  grant_o;
   logic        err_drop_o;
   logic        err_timeout_o;

   midi_tx_arbiter #(.TIMEOUT_CYCLES(16'd16)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .src_data_i(src_data_i), .src_rdy_i(src_rdy_i),
      .src_rd_o(src_rd_o), .out_data_o(out_data_o), .out_wr_o(out_wr_o),
      .out_full_n_i(out_full_n_i), .grant_o(grant_o), .err_drop_o(err_drop_o),
      .err_timeout_o(err_timeout_o));

   always #5 clk_i = ~clk_i;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   logic [7:0] srcq [4][$];
   logic [7:0] obs_q [$];
   logic [3:0] obs_g [$];
   int         obs_c [$];
   logic [7:0] exp_q [$];
   logic [3:0] exp_g [$];
   int drop_cnt, tmo_cnt, tmo_cyc, grant_rises, first_grant_cyc, first_wr_cyc, pop_err;
   logic [3:0] prev_grant = 4'd0;

   logic [7:0] gen_b [4][$];
   int         ml [4][$];
   bit         md [4][$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   initial forever begin
      @(posedge clk_i);
      cyc++;
   end

   // Source FIFO model and output monitor, evaluated mid-cycle.
   initial forever begin
      @(negedge clk_i);
      if (out_wr_o) begin
         obs_q.push_back(out_data_o);
         obs_g.push_back(grant_o);
         obs_c.push_back(cyc);
         if (first_wr_cyc < 0) first_wr_cyc = cyc;
      end
      if (err_drop_o) drop_cnt++;
      if (err_timeout_o) begin
         tmo_cnt++;
         tmo_cyc = cyc;
      end
      if (grant_o != 4'd0 && prev_grant == 4'd0) begin
         grant_rises++;
         if (first_grant_cyc < 0) first_grant_cyc = cyc;
      end
      prev_grant = grant_o;
      for (int n = 0; n < 4; n++) begin
         if (src_rd_o[n]) begin
            if (srcq[n].size() > 0) void'(srcq[n].pop_front());
            else pop_err++;
         end
      end
      for (int n = 0; n < 4; n++) begin
         src_rdy_i[n]        = (srcq[n].size() > 0);
         src_data_i[8*n +: 8] = (srcq[n].size() > 0) ? srcq[n][0] : 8'h00;
      end
   end

   function automatic bit all_empty();
      for (int n = 0; n < 4; n++) if (srcq[n].size() != 0) return 1'b0;
      return 1'b1;
   endfunction

   task automatic do_reset();
      rst_i        = 1'b1;
      out_full_n_i = 1'b1;
      for (int n = 0; n < 4; n++) srcq[n].delete();
      repeat (2) @(posedge clk_i);
      #1;
      check("reset_outputs", {src_rd_o, out_data_o, out_wr_o, grant_o, err_drop_o, err_timeout_o}, 32'd0);
      rst_i = 1'b0;
      obs_q.delete(); obs_g.delete(); obs_c.delete();
      exp_q.delete(); exp_g.delete();
      drop_cnt = 0; tmo_cnt = 0; tmo_cyc = -1; grant_rises = 0;
      first_grant_cyc = -1; first_wr_cyc = -1; pop_err = 0;
   endtask

   task automatic load(input int n, input logic [63:0] b, input int cnt);
      for (int i = 0; i < cnt; i++) srcq[n].push_back(b[8*(cnt-1-i) +: 8]);
   endtask

   task automatic expect_bytes(input logic [63:0] b, input int cnt, input logic [3:0] g);
      for (int i = 0; i < cnt; i++) begin
         exp_q.push_back(b[8*(cnt-1-i) +: 8]);
         exp_g.push_back(g);
      end
   endtask

   task automatic drain(input int maxc, input bit rnd);
      int idle = 0;
      int c = 0;
      while (idle < 4 && c < maxc) begin
         @(posedge clk_i);
         #2;
         c++;
         out_full_n_i = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
         if (all_empty() && grant_o == 4'd0) idle++;
         else idle = 0;
      end
      out_full_n_i = 1'b1;
      check("drain_done", 32'(idle >= 4), 32'd1);
   endtask

   task automatic cmp_stream(input string tag, input bit chk_grant);
      int n;
      check($sformatf("%s_len", tag), obs_q.size(), exp_q.size());
      n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) begin
         check($sformatf("%s_byte%0d", tag, i), obs_q[i], exp_q[i]);
         if (chk_grant) check($sformatf("%s_grant%0d", tag, i), obs_g[i], exp_g[i]);
      end
      check($sformatf("%s_pop_empty", tag), pop_err, 0);
   endtask

   task automatic wait_obs(input int cnt);
      int c = 0;
      while (obs_q.size() < cnt && c < 100) begin
         @(posedge clk_i);
         #1;
         c++;
      end
      check("wait_obs", 32'(obs_q.size() >= cnt), 32'd1);
   endtask

   task automatic gpush(input int p, input logic [7:0] b);
      gen_b[p].push_back(b);
   endtask

   task automatic run_random(input int msgs);
      int t, n, ptr, len, exp_drop;
      logic [7:0] s, b;
      bit rv, r3, found, d;
      for (int p = 0; p < 4; p++) begin
         gen_b[p].delete(); ml[p].delete(); md[p].delete();
         rv = 1'b0; r3 = 1'b0;
         for (int m = 0; m < msgs; m++) begin
            t = $urandom_range(0, 4);
`ifdef MIDI_ARB_RT_BYPASS_EN
            if (t == 4) t = 0;
`endif
            case (t)
               0: begin
                  s  = 8'h80 + 8'($urandom_range(0, 6)) * 8'h10 + 8'($urandom_range(0, 15));
                  r3 = (s < 8'hC0) || (s >= 8'hE0);
                  rv = 1'b1;
                  gpush(p, s);
                  for (int i = 0; i < (r3 ? 2 : 1); i++) gpush(p, 8'($urandom_range(0, 127)));
                  ml[p].push_back(r3 ? 3 : 2); md[p].push_back(1'b0);
               end
               1: begin
                  n = rv ? (r3 ? 2 : 1) : 1;
                  for (int i = 0; i < n; i++) gpush(p, 8'($urandom_range(0, 127)));
                  ml[p].push_back(n); md[p].push_back(!rv);
               end
               2: begin
                  n = $urandom_range(0, 3);
                  gpush(p, 8'hF0);
                  for (int i = 0; i < n; i++) gpush(p, 8'($urandom_range(0, 127)));
                  gpush(p, 8'hF7);
                  ml[p].push_back(n + 2); md[p].push_back(1'b0);
                  rv = 1'b0;
               end
               3: begin
                  n = $urandom_range(0, 3);
                  s = (n == 0) ? 8'hF1 : (n == 1) ? 8'hF2 : (n == 2) ? 8'hF3 : 8'hF6;
                  len = (n == 1) ? 3 : (n == 3) ? 1 : 2;
                  gpush(p, s);
                  for (int i = 1; i < len; i++) gpush(p, 8'($urandom_range(0, 127)));
                  ml[p].push_back(len); md[p].push_back(1'b0);
                  rv = 1'b0;
               end
               default: begin
                  gpush(p, 8'hF8 + 8'($urandom_range(0, 7)));
                  ml[p].push_back(1); md[p].push_back(1'b0);
               end
            endcase
         end
         srcq[p] = gen_b[p];
      end
      // Whole messages leave in round-robin order; orphans vanish.
      ptr = 0; exp_drop = 0;
      do begin
         found = 1'b0;
         for (int k = 0; k < 4 && !found; k++) begin
            n = (ptr + k) % 4;
            if (ml[n].size() > 0) begin
               len = ml[n].pop_front();
               d   = md[n].pop_front();
               for (int i = 0; i < len; i++) begin
                  b = gen_b[n].pop_front();
                  if (d) exp_drop++;
                  else begin
                     exp_q.push_back(b);
                     exp_g.push_back(4'b0001 << n);
                  end
               end
               ptr   = (n + 1) % 4;
               found = 1'b1;
            end
         end
      end while (found);
      drain(8000, 1'b1);
      cmp_stream("rand", 1'b1);
      check("rand_drops", drop_cnt, exp_drop);
      check("rand_timeouts", tmo_cnt, 0);
   endtask

   initial begin
      int n0;
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n0;
      // Two sources ready together; latency and per-message fairness.
      do_reset();
      n0 = cyc;
      load(0, 64'h903C64, 3);
      load(1, 64'hC005, 2);
      expect_bytes(64'h903C64, 3, 4'b0001);
      expect_bytes(64'hC005, 2, 4'b0010);
      drain(200, 1'b0);
      cmp_stream("two_src", 1'b1);
      check("grant_latency", first_grant_cyc - n0, 1);
      check("wr_latency", first_wr_cyc - n0, 2);
      check("two_src_grants", grant_rises, 2);

      // Running status: a second message of data bytes only.
      do_reset();
      load(2, 64'h903C643E50, 5);
      expect_bytes(64'h903C643E50, 5, 4'b0100);
      drain(200, 1'b0);
      cmp_stream("run_status", 1'b1);
      check("run_status_grants", grant_rises, 2);
      check("run_status_drop", drop_cnt, 0);

      // SysEx holds the grant through F7.
      do_reset();
      load(0, 64'hF07E0102F7, 5);
      load(3, 64'h804000, 3);
      expect_bytes(64'hF07E0102F7, 5, 4'b0001);
      expect_bytes(64'h804000, 3, 4'b1000);
      drain(200, 1'b0);
      cmp_stream("sysex", 1'b1);

      // Real-time byte from another source arriving mid-message.
      do_reset();
      load(0, 64'h903C64, 3);
      wait_obs(1);
      load(1, 64'hF8, 1);
`ifdef MIDI_ARB_RT_BYPASS_EN
      expect_bytes(64'h90F83C64, 4, 4'b0001);
`else
      expect_bytes(64'h903C64, 3, 4'b0001);
      expect_bytes(64'hF8, 1, 4'b0010);
`endif
      drain(200, 1'b0);
      cmp_stream("rt", 1'b1);

      // Stalled source is revoked after 16 empty SEND cycles.
      do_reset();
      load(0, 64'h903C, 2);
      load(1, 64'hC005, 2);
      expect_bytes(64'h903C, 2, 4'b0001);
      expect_bytes(64'hC005, 2, 4'b0010);
      drain(400, 1'b0);
      cmp_stream("timeout", 1'b1);
      check("timeout_pulses", tmo_cnt, 1);
      check("timeout_have_3c", 32'(obs_c.size() >= 2), 32'd1);
      if (obs_c.size() >= 2) check("timeout_delay", tmo_cyc - obs_c[1], 17);

      // Orphan data byte, then back-pressure with a message pending.
      do_reset();
      load(1, 64'h40, 1);
      drain(100, 1'b0);
      check("orphan_drop", drop_cnt, 1);
      check("orphan_no_wr", obs_q.size(), 0);
      check("orphan_popped", srcq[1].size(), 0);
      out_full_n_i = 1'b0;
      load(1, 64'h903C64, 3);
      repeat (20) @(posedge clk_i);
      #2;
      check("full_no_wr", obs_q.size(), 0);
      check("full_no_pop", srcq[1].size(), 3);
      check("full_grant_held", grant_o, 4'b0010);
      check("full_no_timeout", tmo_cnt, 0);
      expect_bytes(64'h903C64, 3, 4'b0010);
      drain(200, 1'b0);
      cmp_stream("full", 1'b1);

      // Reset in the middle of a message drops all strobes at the next edge.
      do_reset();
      load(0, 64'h903C64, 3);
      wait_obs(1);
      rst_i = 1'b1;
      @(posedge clk_i);
      #2;
      check("midrst_outputs", {src_rd_o, out_wr_o, grant_o}, 32'd0);

      // Randomized preloaded traffic with random back-pressure.
      for (int r = 0; r < 3; r++) begin
         do_reset();
         run_random(10);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
